// File: rtl/y86_imem_encoder_if.sv
// Instruction/memory bus for y86_imem_encoder.
// The slave modport is the encoder's view; the master modport is the
// view of whatever feeds instructions in and consumes the byte writes.
interface y86_imem_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic        mem_wr_en;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [63:0] pc_next;
    logic        done;
    logic        instr_error;
    logic        imem_error;

    modport slave (
        input  in_valid, icode, ifun, ra, rb, valc,
        output in_ready, mem_wr_en, mem_addr, mem_wdata, pc_next,
               done, instr_error, imem_error
    );

    modport master (
        output in_valid, icode, ifun, ra, rb, valc,
        input  in_ready, mem_wr_en, mem_addr, mem_wdata, pc_next,
               done, instr_error, imem_error
    );
endinterface

// File: rtl/y86_imem_encoder.sv
// Y86-64 instruction-memory writer: serialises one decoded instruction
// into its fetch byte encoding, one byte per cycle, at a running pointer.
// Optional macro ENC_STRICT_CHECK_EN adds ifun/ra/rb legality checks.
module y86_imem_encoder #(
    parameter int          MEM_BYTES = 1024,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic              clock,
    input  logic              reset,
    y86_imem_encoder_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    // Encoded length in bytes; 0 marks an invalid icode.
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
            4'h7, 4'h8:             instr_len = 4'd9;
            4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
            default:                instr_len = 4'd0;
        endcase
    endfunction

    // Byte idx of the encoding; valC is little-endian after the header.
    function automatic logic [7:0] byte_at(input logic [3:0] ic, input logic [3:0] fn,
                                           input logic [3:0] a, input logic [3:0] b,
                                           input logic [63:0] c, input logic [3:0] len,
                                           input logic [3:0] idx);
        logic [2:0] k;
        k = 3'd0;
        if (idx == 4'd0) begin
            byte_at = {ic, fn};
        end else if (len == 4'd9) begin
            k = 3'(idx - 4'd1);
            byte_at = c[{k, 3'b000} +: 8];
        end else if (idx == 4'd1) begin
            byte_at = {a, b};
        end else begin
            k = 3'(idx - 4'd2);
            byte_at = c[{k, 3'b000} +: 8];
        end
    endfunction

`ifdef ENC_STRICT_CHECK_EN
    // Field legality beyond the icode range.
    function automatic logic strict_bad(input logic [3:0] ic, input logic [3:0] fn,
                                        input logic [3:0] a, input logic [3:0] b);
        logic bad;
        case (ic)
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: bad = (fn != 4'd0);
            4'h2, 4'h7: bad = (fn > 4'd6);
            4'h6:       bad = (fn > 4'd3);
            default:    bad = 1'b0;
        endcase
        if (ic == 4'h3 && a != 4'hF) bad = 1'b1;
        if ((ic == 4'hA || ic == 4'hB) && b != 4'hF) bad = 1'b1;
        strict_bad = bad;
    endfunction
`endif

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d, len_q, len_d;
    logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
    logic [63:0] valc_q, valc_d;
    logic [63:0] pc_next_q, pc_next_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        instr_error_q, instr_error_d;
    logic        imem_error_q, imem_error_d;

    logic [3:0]  acc_len;
    logic [64:0] end_addr;
    logic        bad_instr;
    logic        overrun;
    logic [3:0]  idx_nx;

    // Acceptance checks, byte sequencing and pointer update.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        icode_d       = icode_q;
        ifun_d        = ifun_q;
        ra_d          = ra_q;
        rb_d          = rb_q;
        valc_d        = valc_q;
        pc_next_d     = pc_next_q;
        mem_wr_en_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        done_d        = 1'b0;
        instr_error_d = 1'b0;
        imem_error_d  = 1'b0;

        acc_len  = instr_len(bus.icode);
        end_addr = {1'b0, pc_next_q} + 65'(acc_len);
        overrun  = (end_addr > 65'(MEM_BYTES));
`ifdef ENC_STRICT_CHECK_EN
        bad_instr = (bus.icode >= 4'hC) || strict_bad(bus.icode, bus.ifun, bus.ra, bus.rb);
`else
        bad_instr = (bus.icode >= 4'hC);
`endif
        idx_nx = idx_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    icode_d = bus.icode;
                    ifun_d  = bus.ifun;
                    ra_d    = bus.ra;
                    rb_d    = bus.rb;
                    valc_d  = bus.valc;
                    len_d   = acc_len;
                    if (bad_instr) begin
                        instr_error_d = 1'b1;
                    end else if (overrun) begin
                        imem_error_d = 1'b1;
                    end else begin
                        // byte0 goes out on the acceptance edge
                        state_d     = EMIT;
                        idx_d       = 4'd0;
                        mem_wr_en_d = 1'b1;
                        mem_addr_d  = pc_next_q;
                        mem_wdata_d = byte_at(bus.icode, bus.ifun, bus.ra, bus.rb,
                                              bus.valc, acc_len, 4'd0);
                        done_d      = (acc_len == 4'd1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (idx_q == len_q - 4'd1) begin
                    state_d   = IDLE;
                    pc_next_d = pc_next_q + 64'(len_q);
                end else begin
                    idx_d       = idx_nx;
                    mem_wr_en_d = 1'b1;
                    mem_addr_d  = pc_next_q + 64'(idx_nx);
                    mem_wdata_d = byte_at(icode_q, ifun_q, ra_q, rb_q, valc_q, len_q, idx_nx);
                    done_d      = (idx_nx == len_q - 4'd1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= 4'd0;
            len_q         <= 4'd0;
            icode_q       <= 4'd0;
            ifun_q        <= 4'd0;
            ra_q          <= 4'd0;
            rb_q          <= 4'd0;
            valc_q        <= 64'd0;
            pc_next_q     <= BASE_ADDR;
            in_ready_q    <= 1'b1;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= 64'd0;
            mem_wdata_q   <= 8'd0;
            done_q        <= 1'b0;
            instr_error_q <= 1'b0;
            imem_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            icode_q       <= icode_d;
            ifun_q        <= ifun_d;
            ra_q          <= ra_d;
            rb_q          <= rb_d;
            valc_q        <= valc_d;
            pc_next_q     <= pc_next_d;
            in_ready_q    <= in_ready_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            done_q        <= done_d;
            instr_error_q <= instr_error_d;
            imem_error_q  <= imem_error_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.pc_next     = pc_next_q;
    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.done        = done_q;
    assign bus.instr_error = instr_error_q;
    assign bus.imem_error  = imem_error_q;

endmodule

// File: tb/tb_y86_imem_encoder.sv
// Bench for y86_imem_encoder: dut_a uses 1024-byte memory, dut_b a
// 16-byte memory for bounds cases. Expected writes/error pulses are
// queued by the stimulus and popped by a negedge monitor.
module tb_y86_imem_encoder;

    logic clock = 1'b0;
    logic rst_a, rst_b;
    always #5 clock = ~clock;

    y86_imem_encoder_if bus_a ();
    y86_imem_encoder_if bus_b ();

    y86_imem_encoder #(.MEM_BYTES(1024), .BASE_ADDR(64'd0)) dut_a (
        .clock(clock), .reset(rst_a), .bus(bus_a));
    y86_imem_encoder #(.MEM_BYTES(16), .BASE_ADDR(64'd0)) dut_b (
        .clock(clock), .reset(rst_b), .bus(bus_b));

    typedef struct packed {
        logic        wr;
        logic        ierr;
        logic        merr;
        logic [63:0] addr;
        logic [7:0]  data;
        logic        done;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    int  total = 0;
    int  bad   = 0;
    int  lat;
    logic [63:0] p_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input bit s, input ev_t e);
        if (s) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    // bytes[7:0] is byte0 of the encoding.
    task automatic push_bytes(input bit s, input logic [63:0] base, input int n,
                              input logic [79:0] bytes, input bit with_done);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            e      = '0;
            e.wr   = 1'b1;
            e.addr = base + 64'(i);
            e.data = bytes[8*i +: 8];
            e.done = with_done && (i == n - 1);
            push_ev(s, e);
        end
    endtask

    task automatic push_err(input bit s, input bit imem);
        ev_t e;
        e      = '0;
        e.ierr = !imem;
        e.merr = imem;
        push_ev(s, e);
    endtask

    function automatic logic rdy(input bit s);
        return s ? bus_b.in_ready : bus_a.in_ready;
    endfunction

    function automatic logic [63:0] pc(input bit s);
        return s ? bus_b.pc_next : bus_a.pc_next;
    endfunction

    // Expects to be called just after a negedge.
    task automatic send(input bit s, input logic [3:0] ic, input logic [3:0] f,
                        input logic [3:0] a, input logic [3:0] b, input logic [63:0] c,
                        input bit wait_end, output int l);
        int n = 0;
        while (!rdy(s) && n < 100) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL send_wait_ready: got timeout expected in_ready");
        end
        if (s) begin
            bus_b.icode = ic; bus_b.ifun = f; bus_b.ra = a; bus_b.rb = b; bus_b.valc = c;
            bus_b.in_valid = 1'b1;
        end else begin
            bus_a.icode = ic; bus_a.ifun = f; bus_a.ra = a; bus_a.rb = b; bus_a.valc = c;
            bus_a.in_valid = 1'b1;
        end
        @(posedge clock);
        #1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        l = 0;
        if (wait_end) begin
            do begin
                @(negedge clock);
                l++;
            end while (!rdy(s) && l < 100);
        end
    endtask

    task automatic mon(input bit s, input ev_t obs);
        ev_t e;
        if (obs.wr === 1'b1 || obs.ierr === 1'b1 || obs.merr === 1'b1 || obs.done === 1'b1) begin
            total++;
            if ((s ? qb.size() : qa.size()) == 0) begin
                bad++;
                $display("FAIL mon_%0d_unexpected: got wr=%b ierr=%b merr=%b addr=%0h data=%0h done=%b expected no event",
                         s, obs.wr, obs.ierr, obs.merr, obs.addr, obs.data, obs.done);
            end else begin
                e = s ? qb.pop_front() : qa.pop_front();
                if (e.wr ? (obs !== e)
                         : ({obs.wr, obs.ierr, obs.merr, obs.done} !== {e.wr, e.ierr, e.merr, e.done})) begin
                    bad++;
                    $display("FAIL mon_%0d_event: got wr=%b ierr=%b merr=%b addr=%0h data=%0h done=%b expected wr=%b ierr=%b merr=%b addr=%0h data=%0h done=%b",
                             s, obs.wr, obs.ierr, obs.merr, obs.addr, obs.data, obs.done,
                             e.wr, e.ierr, e.merr, e.addr, e.data, e.done);
                end
            end
        end
    endtask

    // Scoreboard monitor for both instances.
    always @(negedge clock) begin
        mon(1'b0, {bus_a.mem_wr_en, bus_a.instr_error, bus_a.imem_error,
                   bus_a.mem_addr, bus_a.mem_wdata, bus_a.done});
        mon(1'b1, {bus_b.mem_wr_en, bus_b.instr_error, bus_b.imem_error,
                   bus_b.mem_addr, bus_b.mem_wdata, bus_b.done});
    end

    task automatic reset_a();
        rst_a = 1'b1;
        @(negedge clock);
        rst_a = 1'b0;
    endtask

    initial begin
        bus_a.in_valid = 1'b0; bus_a.icode = 4'd0; bus_a.ifun = 4'd0;
        bus_a.ra = 4'd0; bus_a.rb = 4'd0; bus_a.valc = 64'd0;
        bus_b.in_valid = 1'b0; bus_b.icode = 4'd0; bus_b.ifun = 4'd0;
        bus_b.ra = 4'd0; bus_b.rb = 4'd0; bus_b.valc = 64'd0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clock);

        // reset state
        chk("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        chk("rst_pc_next", bus_a.pc_next, 64'd0);
        chk("rst_mem_wr_en", 64'(bus_a.mem_wr_en), 64'd0);
        chk("rst_mem_addr", bus_a.mem_addr, 64'd0);
        chk("rst_mem_wdata", 64'(bus_a.mem_wdata), 64'd0);
        chk("rst_done", 64'(bus_a.done), 64'd0);
        chk("rst_instr_error", 64'(bus_a.instr_error), 64'd0);
        chk("rst_imem_error", 64'(bus_a.imem_error), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // irmovq $10, %rdx
        push_bytes(1'b0, 64'd0, 10, 80'h00_00_00_00_00_00_00_0A_F2_30, 1'b1);
        send(1'b0, 4'h3, 4'h0, 4'hF, 4'h2, 64'h0000_0000_0000_000A, 1'b1, lat);
        chk("irmovq_ready_latency", 64'(lat), 64'd11);
        chk("irmovq_pc_next", pc(1'b0), 64'd10);

        // addq / jmp / halt back to back from a fresh reset
        reset_a();
        push_bytes(1'b0, 64'd0, 2, 80'h23_60, 1'b1);
        send(1'b0, 4'h6, 4'h0, 4'h2, 4'h3, 64'hDEAD_BEEF_0000_0000, 1'b1, lat);
        chk("opq_ready_latency", 64'(lat), 64'd3);
        push_bytes(1'b0, 64'd2, 9, 80'h00_00_00_00_00_00_00_20_70, 1'b1);
        send(1'b0, 4'h7, 4'h0, 4'h5, 4'h6, 64'h20, 1'b1, lat);
        chk("jxx_ready_latency", 64'(lat), 64'd10);
        push_bytes(1'b0, 64'd11, 1, 80'h00, 1'b1);
        send(1'b0, 4'h0, 4'h0, 4'h7, 4'h8, 64'h1234, 1'b1, lat);
        chk("halt_ready_latency", 64'(lat), 64'd2);
        chk("seq_pc_next", pc(1'b0), 64'd12);

        // invalid icode, then a nop at the unchanged address
        push_err(1'b0, 1'b0);
        send(1'b0, 4'hD, 4'h0, 4'h1, 4'h2, 64'h55, 1'b1, lat);
        chk("bad_icode_ready_stays", 64'(lat), 64'd1);
        chk("bad_icode_pc_next", pc(1'b0), 64'd12);
        push_bytes(1'b0, 64'd12, 1, 80'h10, 1'b1);
        send(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b1, lat);
        chk("nop_pc_next", pc(1'b0), 64'd13);

        // OPq with ifun=5
`ifdef ENC_STRICT_CHECK_EN
        push_err(1'b0, 1'b0);
        p_exp = 64'd13;
`else
        push_bytes(1'b0, 64'd13, 2, 80'h23_65, 1'b1);
        p_exp = 64'd15;
`endif
        send(1'b0, 4'h6, 4'h5, 4'h2, 4'h3, 64'h0, 1'b1, lat);
        chk("opq_ifun5_pc_next", pc(1'b0), p_exp);

        // reset while the 4th byte of rmmovq is on the bus
        push_bytes(1'b0, p_exp, 4, 80'h01_00_12_40, 1'b0);
        send(1'b0, 4'h4, 4'h0, 4'h1, 4'h2, 64'h100, 1'b0, lat);
        repeat (4) @(negedge clock);
        rst_a = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_mem_wr_en", 64'(bus_a.mem_wr_en), 64'd0);
        chk("abort_done", 64'(bus_a.done), 64'd0);
        chk("abort_pc_next", bus_a.pc_next, 64'd0);
        @(negedge clock);
        rst_a = 1'b0;
        chk("abort_in_ready", 64'(bus_a.in_ready), 64'd1);

        // 16-byte memory: fill to 8, overrun, then fill exactly to 16
        for (int i = 0; i < 4; i++) begin
            push_bytes(1'b1, 64'(2 * i), 2, 80'h12_20, 1'b1);
            send(1'b1, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 1'b1, lat);
        end
        chk("small_pc_8", pc(1'b1), 64'd8);
        push_err(1'b1, 1'b1);
        send(1'b1, 4'h3, 4'h0, 4'hF, 4'h4, 64'h1234, 1'b1, lat);
        chk("overrun_pc_next", pc(1'b1), 64'd8);
        for (int i = 0; i < 4; i++) begin
            push_bytes(1'b1, 64'(8 + 2 * i), 2, 80'h12_20, 1'b1);
            send(1'b1, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 1'b1, lat);
        end
        chk("exact_fit_pc_next", pc(1'b1), 64'd16);
        push_err(1'b1, 1'b1);
        send(1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b1, lat);
        chk("full_nop_pc_next", pc(1'b1), 64'd16);
        // invalid and overrunning: instr_error only
        push_err(1'b1, 1'b0);
        send(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 64'h0, 1'b1, lat);
        chk("priority_pc_next", pc(1'b1), 64'd16);

        repeat (3) @(negedge clock);
        chk("queue_a_drained", 64'(qa.size()), 64'd0);
        chk("queue_b_drained", 64'(qb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
